// File: rtl/counter_sequencer_pkg.sv
// ============================================================================
//  Module      : counter_sequencer_pkg
//  Description : Shared types and constants for the counter run-control
//                sequencer: FSM state encoding and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_sequencer_pkg;

    // Default datapath widths
    localparam int c_DEF_WIDTH      = 4;
    localparam int c_DEF_PRESCALE_W = 4;

    // Externally visible state encoding (also driven on the state port)
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = c_ST_IDLE,
        S_RUN    = c_ST_RUN,
        S_PAUSED = c_ST_PAUSED,
        S_DONE   = c_ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_core.sv
// ============================================================================
//  Module      : counter_core
//  Description : WIDTH-bit up-counter register with synchronous clear and
//                count enable; clear wins over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Counter register: clear has priority, otherwise step when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
//  Module      : counter_sequencer
//  Description : Run-control sequencer for the binary counter datapath.
//                Starts, pauses, stops and reloads a WIDTH-bit up-counter
//                against a terminal value, paced by a programmable
//                prescaler, and pulses done at terminal count.
//                Optional macro COUNTER_SEQUENCER_RELOAD_CNT_EN enables the
//                saturating auto-reload event counter on reload_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int PRESCALE_W = c_DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      compare_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state,
    output logic [7:0]            reload_cnt
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_cmp_s;
    logic [PRESCALE_W-1:0] r_pre_s;
    logic                  r_ar_s;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PRESCALE_W-1:0] w_pre_cnt_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_clr;
    logic                  w_en;
    logic                  w_start_acc;
    logic                  w_tick;
    logic                  w_at_term;
    logic [WIDTH-1:0]      w_count;

    // Counter datapath; only this block drives its clear and enable
    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_count)
    );

    assign w_tick    = (r_pre_cnt == r_pre_s);
    assign w_at_term = (w_count == r_cmp_s);

    // Next-state, counter control and prescaler decode; stop > start > pause
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_done_nxt    = 1'b0;
        w_clr         = 1'b0;
        w_en          = 1'b0;
        w_start_acc   = 1'b0;
        if (stop) begin
            w_state_nxt   = S_IDLE;
            w_pre_cnt_nxt = '0;
            w_clr         = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_IDLE) begin
                        w_pre_cnt_nxt = '0;
                    end
                    if (start) begin
                        w_state_nxt   = S_RUN;
                        w_pre_cnt_nxt = '0;
                        w_clr         = 1'b1;
                        w_start_acc   = 1'b1;
                    end
                end
                S_RUN: begin
                    // Pausing freezes everything; no tick is evaluated
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (w_tick) begin
                        w_pre_cnt_nxt = '0;
                        if (w_at_term) begin
                            w_done_nxt = 1'b1;
                            if (r_ar_s) begin
                                w_clr = 1'b1;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_en = 1'b1;
                        end
                    end else begin
                        w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, prescaler phase and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Run configuration is latched only when a start is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_s <= '0;
            r_pre_s <= '0;
            r_ar_s  <= 1'b0;
        end else if (w_start_acc) begin
            r_cmp_s <= compare_val;
            r_pre_s <= prescale;
            r_ar_s  <= auto_reload;
        end
    end

`ifdef COUNTER_SEQUENCER_RELOAD_CNT_EN
    logic [7:0] r_reload_cnt;
    logic       w_reload;

    // An auto-reload event is a terminal tick in periodic mode
    assign w_reload = (r_state == S_RUN) && !stop && !pause &&
                      w_tick && w_at_term && r_ar_s;

    // Saturating count of auto-reload events, cleared per run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload_cnt <= 8'd0;
        end else if (stop || w_start_acc) begin
            r_reload_cnt <= 8'd0;
        end else if (w_reload && (r_reload_cnt != 8'hFF)) begin
            r_reload_cnt <= r_reload_cnt + 8'd1;
        end
    end

    assign reload_cnt = r_reload_cnt;
`else
    assign reload_cnt = 8'd0;
`endif

    assign count = w_count;
    assign done  = r_done;
    assign state = r_state;
    assign busy  = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ============================================================================
//  Module      : tb_counter_sequencer
//  Description : Self-checking bench for counter_sequencer: directed
//                scenarios with literal expectations plus a randomized run
//                checked against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] compare_val = 4'd0;
    logic [3:0] prescale = 4'd0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic [7:0] reload_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model of the run-control rules
    int m_state = 0;  // 0 idle, 1 run, 2 paused, 3 done
    int m_count = 0;
    int m_pre   = 0;
    int m_cmp   = 0;
    int m_pre_s = 0;
    int m_ar    = 0;
    int m_done  = 0;
    int m_rel   = 0;

    counter_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .compare_val (compare_val),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state),
        .reload_cnt  (reload_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_pre = 0; m_cmp = 0;
        m_pre_s = 0; m_ar = 0; m_done = 0; m_rel = 0;
    endtask

    // one rising edge of the reference, using the inputs present at the edge
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (stop) begin
            m_state = 0; m_count = 0; m_pre = 0; m_rel = 0;
        end else if ((m_state == 0 || m_state == 3) && start) begin
            m_cmp = compare_val; m_pre_s = prescale; m_ar = auto_reload;
            m_state = 1; m_count = 0; m_pre = 0; m_rel = 0;
        end else if (m_state == 1) begin
            if (pause) begin
                m_state = 2;
            end else if (m_pre == m_pre_s) begin
                m_pre = 0;
                if (m_count == m_cmp) begin
                    m_done = 1;
                    if (m_ar != 0) begin
                        m_count = 0;
                        if (m_rel < 255) m_rel++;
                    end else begin
                        m_state = 3;
                    end
                end else begin
                    m_count++;
                end
            end else begin
                m_pre++;
            end
        end else if (m_state == 2 && !pause) begin
            m_state = 1;
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        clk_step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_step();
        clk_step();
        n_total++;
        if (count !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || reload_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: count=%0d state=%0d busy=%0d done=%0d reload=%0d, required all 0",
                     count, state, busy, done, reload_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_one_shot();
        compare_val = 4'd3; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
        clk_step();
        start = 1'b0;
        n_total++;
        if (state !== 2'd1 || count !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL one_shot_entry: state=%0d count=%0d busy=%0d, required 1 0 1", state, count, busy);
        end
        for (int k = 1; k <= 3; k++) begin
            clk_step();
            n_total++;
            if (count !== 4'(k) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL one_shot_count: edge %0d count=%0d done=%0d, required %0d 0", k, count, done, k);
            end
        end
        clk_step();
        n_total++;
        if (done !== 1'b1 || state !== 2'd3 || count !== 4'd3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL one_shot_done: done=%0d state=%0d count=%0d busy=%0d, required 1 3 3 0",
                     done, state, count, busy);
        end
        clk_step();
        n_total++;
        if (done !== 1'b0 || state !== 2'd3 || count !== 4'd3) begin
            n_bad++;
            $display("FAIL one_shot_hold: done=%0d state=%0d count=%0d, required 0 3 3", done, state, count);
        end
        do_stop();
        n_total++;
        if (state !== 2'd0 || count !== 4'd0) begin
            n_bad++;
            $display("FAIL stop_from_done: state=%0d count=%0d, required 0 0", state, count);
        end
    endtask

    task automatic test_periodic();
        int exp_rel;
        compare_val = 4'd2; prescale = 4'd2; auto_reload = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            clk_step();
            n_total++;
            if (count !== 4'((k / 3) % 3) || done !== ((k % 9) == 0)) begin
                n_bad++;
                $display("FAIL periodic: edge %0d count=%0d done=%0d, required %0d %0d",
                         k, count, done, (k / 3) % 3, (k % 9) == 0);
            end
        end
`ifdef COUNTER_SEQUENCER_RELOAD_CNT_EN
        exp_rel = 2;
`else
        exp_rel = 0;
`endif
        n_total++;
        if (reload_cnt !== 8'(exp_rel) || state !== 2'd1) begin
            n_bad++;
            $display("FAIL periodic_reload: reload=%0d state=%0d, required %0d 1", reload_cnt, state, exp_rel);
        end
        do_stop();
        n_total++;
        if (reload_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reload_clear_on_stop: reload=%0d, required 0", reload_cnt);
        end
    endtask

    task automatic test_pause();
        compare_val = 4'd9; prescale = 4'd1; auto_reload = 1'b0; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) clk_step();
        n_total++;
        if (count !== 4'd4) begin
            n_bad++;
            $display("FAIL pause_pre: count=%0d, required 4", count);
        end
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            n_total++;
            if (state !== 2'd2 || count !== 4'd4 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL paused: cycle %0d state=%0d count=%0d busy=%0d, required 2 4 1",
                         k, state, count, busy);
            end
        end
        pause = 1'b0;
        clk_step();
        n_total++;
        if (state !== 2'd1 || count !== 4'd4) begin
            n_bad++;
            $display("FAIL resume: state=%0d count=%0d, required 1 4", state, count);
        end
        clk_step();
        n_total++;
        if (count !== 4'd5) begin
            n_bad++;
            $display("FAIL resume_phase: count=%0d, required 5", count);
        end
        do_stop();
    endtask

    task automatic test_priority();
        compare_val = 4'd3; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
        clk_step();
        start = 1'b1; stop = 1'b1;
        clk_step();
        stop = 1'b0;
        n_total++;
        if (state !== 2'd0 || count !== 4'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_stop_same: state=%0d count=%0d done=%0d, required 0 0 0", state, count, done);
        end
        // start still high: accepted from IDLE, then held into RUN
        clk_step();
        compare_val = 4'd1;
        clk_step();
        clk_step();
        start = 1'b0;
        clk_step();
        n_total++;
        if (count !== 4'd3 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL cmp_shadow: count=%0d state=%0d, required 3 1", count, state);
        end
        clk_step();
        n_total++;
        if (done !== 1'b1 || state !== 2'd3 || count !== 4'd3) begin
            n_bad++;
            $display("FAIL cmp_shadow_end: done=%0d state=%0d count=%0d, required 1 3 3", done, state, count);
        end
        do_stop();
    endtask

    task automatic test_edges();
        compare_val = 4'd0; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
        n_total++;
        if (done !== 1'b1 || count !== 4'd0 || state !== 2'd3) begin
            n_bad++;
            $display("FAIL cmp_zero: done=%0d count=%0d state=%0d, required 1 0 3", done, count, state);
        end
        do_stop();
        compare_val = 4'd15; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) clk_step();
        n_total++;
        if (count !== 4'd15 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_max_reach: count=%0d done=%0d, required 15 0", count, done);
        end
        clk_step();
        clk_step();
        n_total++;
        if (count !== 4'd15 || state !== 2'd3) begin
            n_bad++;
            $display("FAIL cmp_max_nowrap: count=%0d state=%0d, required 15 3", count, state);
        end
        auto_reload = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) clk_step();
        n_total++;
        if (count !== 4'd0 || done !== 1'b1 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL cmp_max_reload: count=%0d done=%0d state=%0d, required 0 1 1", count, done, state);
        end
        do_stop();
        auto_reload = 1'b0;
    endtask

    task automatic test_async_reset();
        compare_val = 4'd9; prescale = 4'd0; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) clk_step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (count !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: count=%0d state=%0d busy=%0d done=%0d, required all 0",
                     count, state, busy, done);
        end
        #2;
        rst = 1'b0;
        compare_val = 4'd2; start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
        clk_step();
        n_total++;
        if (count !== 4'd2 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_run: count=%0d done=%0d, required 2 0", count, done);
        end
        clk_step();
        n_total++;
        if (done !== 1'b1 || state !== 2'd3) begin
            n_bad++;
            $display("FAIL post_reset_done: done=%0d state=%0d, required 1 3", done, state);
        end
        do_stop();
    endtask

    task automatic test_reload_saturate();
        int exp_rel;
        compare_val = 4'd0; prescale = 4'd0; auto_reload = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 0; k < 300; k++) clk_step();
`ifdef COUNTER_SEQUENCER_RELOAD_CNT_EN
        exp_rel = 255;
`else
        exp_rel = 0;
`endif
        n_total++;
        if (reload_cnt !== 8'(exp_rel)) begin
            n_bad++;
            $display("FAIL reload_saturate: reload=%0d, required %0d", reload_cnt, exp_rel);
        end
        do_stop();
        auto_reload = 1'b0;
    endtask

    task automatic test_random();
        int exp_rel;
        for (int k = 0; k < 2000; k++) begin
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 24) == 0);
            pause       = ($urandom_range(0, 4) == 0);
            auto_reload = $urandom_range(0, 1);
            compare_val = 4'($urandom_range(0, 5));
            prescale    = 4'($urandom_range(0, 2));
            clk_step();
`ifdef COUNTER_SEQUENCER_RELOAD_CNT_EN
            exp_rel = m_rel;
`else
            exp_rel = 0;
`endif
            n_total++;
            if (count !== 4'(m_count) || state !== 2'(m_state) || done !== 1'(m_done) ||
                busy !== (m_state == 1 || m_state == 2) || reload_cnt !== 8'(exp_rel)) begin
                n_bad++;
                $display("FAIL random: cycle %0d count=%0d state=%0d done=%0d busy=%0d reload=%0d, required %0d %0d %0d %0d %0d",
                         k, count, state, done, busy, reload_cnt,
                         m_count, m_state, m_done, (m_state == 1 || m_state == 2), exp_rel);
            end
        end
        start = 1'b0; pause = 1'b0;
        do_stop();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_priority();
        test_edges();
        test_async_reset();
        test_reload_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control sequencer for the team's binary counter datapath. It starts, pauses, stops and reloads a WIDTH-bit up-counter against a programmable terminal value. A programmable prescaler paces the count. A one-cycle done pulse is raised at terminal count. It sits between the control/register logic and the counter core, and is the only block allowed to drive the counter's enable and clear.

Parameters:
WIDTH, 4, counter and compare value width in bits.
PRESCALE_W, 4, prescaler width; the count steps once every prescale+1 clock cycles.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  pulse; begins a run from IDLE or DONE.
stop  input  1  pulse; aborts from any state and returns to IDLE.
pause  input  1  level; holds the run while it is high.
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at start.
compare_val  input  WIDTH  terminal count; sampled at start.
prescale  input  PRESCALE_W  step divider; sampled at start.
count  output  WIDTH  current counter value.
busy  output  1  high in RUN or PAUSED.
done  output  1  one-cycle pulse at terminal count.
state  output  2  FSM state: IDLE=0, RUN=1, PAUSED=2, DONE=3.
reload_cnt  output  8  number of auto-reload events (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. Under reset, all outputs and registers go to 0 and state goes to IDLE.
- Shadow registers: cmp_s, pre_s and ar_s capture compare_val, prescale and auto_reload on the edge that accepts start. Input changes during a run are ignored.
- Prescaler: pre_cnt counts while state==RUN. tick = (pre_cnt==pre_s). On a tick, pre_cnt returns to 0; otherwise it increments. pre_cnt holds in PAUSED and clears in IDLE.
- Priority per edge: stop > start > pause.
- IDLE: start moves to RUN with count=0 and pre_cnt=0. pause is ignored.
- RUN:
  - pause=1 moves to PAUSED; count and pre_cnt are frozen, and no tick is evaluated on that edge.
  - On tick with count!=cmp_s: count <= count+1.
  - On tick with count==cmp_s: done <= 1 for exactly one cycle.
    - If ar_s=1: count <= 0 and the FSM stays in RUN.
    - If ar_s=0: the FSM goes to DONE and count holds at cmp_s.
- PAUSED: pause=0 returns to RUN and resumes from the frozen pre_cnt and count. start is ignored.
- DONE: count holds. start rearms the block exactly as from IDLE. stop goes to IDLE and clears count.
- stop in any state: next state is IDLE, count=0, pre_cnt=0, done=0.
- Latency: with pre_s=0, count steps on every RUN edge after the entry edge. done asserts on the edge after count reaches cmp_s.
- compare_val=0: done fires on the first tick. Count stays 0.
- compare_val=all-ones: count reaches 2^WIDTH-1 and never wraps through the adder. Wrap happens only via reload.
- start and stop in the same cycle: stop wins.
- A start pulse held for several cycles in RUN has no effect.
- rst mid-run: immediate return to IDLE with all outputs at 0, with no done pulse.
- busy = (state==RUN) or (state==PAUSED), decoded combinationally from the state register.

Optional Feature:
Macro COUNTER_SEQUENCER_RELOAD_CNT_EN.
- When defined: reload_cnt increments on every auto-reload done pulse and saturates at 255. It clears on rst, on stop, and on an accepted start.
- When not defined: reload_cnt is tied to 0 and no register is inferred. The port list is unchanged.

Decomposition:
- Package counter_sequencer_pkg holds:
  - the state enum typedef (2-bit: IDLE, RUN, PAUSED, DONE);
  - the state encoding constants;
  - default WIDTH and PRESCALE_W localparams.
- One sub-module, counter_core: WIDTH-bit register with clk, rst, clr, en and count, with clr taking priority over en. The sequencer instantiates it and drives clr and en.
- The FSM, prescaler and shadow registers remain in counter_sequencer.

Test Plan:
- One-shot: prescale=0, cmp=3, ar=0, start at edge 0 → count 1,2,3 at edges 1–3; done=1 after edge 4; state=DONE; count stays 3.
- Periodic with prescale: prescale=2, cmp=2, ar=1 → count steps every 3 cycles 0,1,2,0,1; done pulses every 9 cycles; reload_cnt=2 after 18 cycles (macro defined), 0 otherwise.
- Pause: cmp=9, pause high for 5 cycles at count=4 → state=PAUSED and count=4 throughout; resumes at 5 with pre_cnt phase preserved.
- Priority: start and stop together from RUN → IDLE, count=0; compare_val changed mid-run from 3 to 1 → run still ends at 3.
- Edges: cmp=0 → done one tick after start; cmp=15 with WIDTH=4 → count reaches 15, one-shot ends with no wrap; ar=1 → 15→0.
- Reset: assert rst asynchronously mid-clock at count=5 in RUN → outputs 0 and IDLE immediately, before the next edge; no done pulse; subsequent start behaves normally.
